step_sequencer_controller: RTL and testbench

//  Owns the 16-step pattern for the sequencer and runs playback.

---
 rtl/step_sequencer_controller_if.sv | 25 ++
 rtl/step_sequencer_controller.sv | 165 ++++++++++++++++
 tb/tb_step_sequencer_controller.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/step_sequencer_controller_if.sv
// Bus between the sequencer controller and its surroundings: scanner reports
// and transport controls in, pattern and playback state out.
interface step_sequencer_controller_if;
  logic [3:0]  button_index;
  logic        button_pressed;
  logic        run;
  logic        clear;
  logic [15:0] pattern;
  logic [3:0]  playhead;
  logic        running;
  logic        step_tick;
  logic        step_trigger;

  // Side that drives the scanner/transport inputs and observes playback.
  modport master (
    output button_index, button_pressed, run, clear,
    input  pattern, playhead, running, step_tick, step_trigger
  );

  // The controller itself.
  modport slave (
    input  button_index, button_pressed, run, clear,
    output pattern, playhead, running, step_tick, step_trigger
  );
endinterface

// File: rtl/step_sequencer_controller.sv
// 16-step pattern owner and playback engine. Press reports from the matrix
// scanner toggle pattern bits (one toggle per physical press, a held key is
// recognised by repeated reports of the same index); a STOP/PLAY FSM walks a
// playhead at a fixed tempo and emits step_tick / step_trigger pulses.
//
// Handshake: there is no valid/ready pair. button_index is qualified by the
// 0->1 edge of button_pressed (one edge = one report); run and clear are
// levels sampled every cycle; every output is a register.
module step_sequencer_controller #(
  parameter int TICKS_PER_STEP = 1_500_000,
  parameter int RELEASE_TICKS  = 24_000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  step_sequencer_controller_if.slave  bus,
  output logic                        state_o
);

  localparam int CW = (TICKS_PER_STEP > 2) ? $clog2(TICKS_PER_STEP) : 1;
  localparam int HW = $clog2(RELEASE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TICKS_PER_STEP - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(RELEASE_TICKS - 1);

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          bp_q, report_q;
  logic [3:0]    idx_q;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    held_q, held_d;
  logic [15:0]   pattern_q, pattern_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    playhead_q, playhead_d;
  logic [3:0]    next_ph;
  logic          tick_q, tick_d;
  logic          trig_q, trig_d;
  logic          running;

  // Registered edge detect: the report and its index are both registered,
  // so the pattern changes two edges after button_pressed rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_q     <= 1'b0;
      report_q <= 1'b0;
      idx_q    <= 4'd0;
    end else begin
      bp_q     <= bus.button_pressed;
      report_q <= bus.button_pressed & ~bp_q;
      idx_q    <= bus.button_index;
    end
  end

  // Press qualification: a report toggles only if no key is held or it is a
  // different key; every report re-arms the hold timer. clear wins over a
  // toggle but the hold bookkeeping still advances.
  always_comb begin
    pattern_d = pattern_q;
    hold_d    = hold_q;
    held_d    = held_q;
    if (report_q) begin
      hold_d = HOLD_LOAD;
      if (hold_q == '0 || idx_q != held_q) begin
        pattern_d = pattern_q ^ (16'(1) << idx_q);
        held_d    = idx_q;
      end
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end
    if (bus.clear) begin
      pattern_d = '0;
    end
  end

  // Pattern and hold-tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= '0;
      hold_q    <= '0;
      held_q    <= 4'd0;
    end else begin
      pattern_q <= pattern_d;
      hold_q    <= hold_d;
      held_q    <= held_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STOP;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: run is a plain level.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: if (bus.run)  state_d = ST_PLAY;
      ST_PLAY: if (!bus.run) state_d = ST_STOP;
      default: state_d = ST_STOP;
    endcase
  end

  // FSM outputs and playback datapath next values. Triggers sample the
  // registered pattern, i.e. before any same-cycle toggle or clear lands.
  always_comb begin
    cnt_d      = cnt_q;
    playhead_d = playhead_q;
    tick_d     = 1'b0;
    trig_d     = 1'b0;
    next_ph    = playhead_q + 4'd1;
    running    = (state_q == ST_PLAY);
    case (state_q)
      ST_STOP: begin
        cnt_d = '0;
        if (bus.run) begin
          playhead_d = 4'd0;
          tick_d     = 1'b1;
          trig_d     = pattern_q[0];
        end
      end
      ST_PLAY: begin
        if (!bus.run) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d      = '0;
          playhead_d = next_ph;
          tick_d     = 1'b1;
          trig_d     = pattern_q[next_ph];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // Playback registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      playhead_q <= 4'd0;
      tick_q     <= 1'b0;
      trig_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      playhead_q <= playhead_d;
      tick_q     <= tick_d;
      trig_q     <= trig_d;
    end
  end

  assign bus.pattern      = pattern_q;
  assign bus.playhead     = playhead_q;
  assign bus.running      = running;
  assign bus.step_tick    = tick_q;
  assign bus.step_trigger = trig_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_step_sequencer_controller.sv
// Directed bench for step_sequencer_controller with TICKS_PER_STEP=4 and
// RELEASE_TICKS=10. Inputs are driven and outputs sampled on the falling edge.
module tb_step_sequencer_controller;

  logic clk = 1'b0;
  logic rst_n;
  logic state_dbg;
  int   checks = 0;
  int   errors = 0;

  step_sequencer_controller_if bus();

  step_sequencer_controller #(
    .TICKS_PER_STEP(4),
    .RELEASE_TICKS (10)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .state_o(state_dbg)
  );

  // Clock / reset-independent watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.run = 1'b1;
    bus.clear = 1'b0;
    bus.button_pressed = 1'b0;
    bus.button_index = 4'd0;
    cyc(3);
    checks++; if (bus.pattern !== 16'h0000) begin errors++; $display("FAIL rst_pattern got %h want 0000", bus.pattern); end
    checks++; if (bus.playhead !== 4'd0) begin errors++; $display("FAIL rst_playhead got %0d want 0", bus.playhead); end
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL rst_running got %b want 0", bus.running); end
    checks++; if (bus.step_tick !== 1'b0 || bus.step_trigger !== 1'b0) begin errors++; $display("FAIL rst_pulses got %b%b want 00", bus.step_tick, bus.step_trigger); end
    checks++; if (state_dbg !== 1'b0) begin errors++; $display("FAIL rst_state got %b want 0", state_dbg); end
    rst_n = 1'b1;
    cyc(1);
    checks++; if (bus.running !== 1'b1 || bus.step_tick !== 1'b1) begin errors++; $display("FAIL rst_first_tick got run=%b tick=%b want 1 1", bus.running, bus.step_tick); end
    checks++; if (bus.playhead !== 4'd0 || bus.step_trigger !== 1'b0) begin errors++; $display("FAIL rst_first_step got ph=%0d trig=%b want 0 0", bus.playhead, bus.step_trigger); end
    cyc(1);
    checks++; if (bus.step_tick !== 1'b0) begin errors++; $display("FAIL rst_tick_pulse got %b want 0", bus.step_tick); end
    bus.run = 1'b0;
    cyc(1);
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL rst_stop got %b want 0", bus.running); end
  endtask

  task automatic test_single_press();
    bus.button_index = 4'd5;
    bus.button_pressed = 1'b1;
    cyc(1);
    checks++; if (bus.pattern !== 16'h0000) begin errors++; $display("FAIL press_latency got %h want 0000", bus.pattern); end
    cyc(1);
    checks++; if (bus.pattern !== 16'h0020) begin errors++; $display("FAIL press_single got %h want 0020", bus.pattern); end
    cyc(1);
    bus.button_pressed = 1'b0;
    cyc(2);
    bus.button_pressed = 1'b1;
    cyc(3);
    bus.button_pressed = 1'b0;
    cyc(1);
    checks++; if (bus.pattern !== 16'h0020) begin errors++; $display("FAIL press_bounce got %h want 0020", bus.pattern); end
    bus.clear = 1'b1;
    cyc(1);
    bus.clear = 1'b0;
    checks++; if (bus.pattern !== 16'h0000) begin errors++; $display("FAIL clear got %h want 0000", bus.pattern); end
    cyc(12);
  endtask

  task automatic test_held_key();
    bus.button_index = 4'd5;
    for (int i = 0; i < 5; i++) begin
      bus.button_pressed = 1'b1;
      cyc(3);
      bus.button_pressed = 1'b0;
      cyc(5);
    end
    checks++; if (bus.pattern !== 16'h0020) begin errors++; $display("FAIL held_one_toggle got %h want 0020", bus.pattern); end
    cyc(12);
    bus.button_pressed = 1'b1;
    cyc(2);
    checks++; if (bus.pattern !== 16'h0000) begin errors++; $display("FAIL release_retoggle got %h want 0000", bus.pattern); end
    bus.button_pressed = 1'b0;
    cyc(1);
    bus.button_index = 4'd6;
    bus.button_pressed = 1'b1;
    cyc(2);
    checks++; if (bus.pattern !== 16'h0040) begin errors++; $display("FAIL new_index got %h want 0040", bus.pattern); end
    bus.button_pressed = 1'b0;
    cyc(1);
  endtask

  task automatic test_playback();
    logic exp_trig;
    bus.clear = 1'b1;
    cyc(1);
    bus.clear = 1'b0;
    bus.button_index = 4'd0;
    bus.button_pressed = 1'b1;
    cyc(2);
    bus.button_pressed = 1'b0;
    cyc(1);
    bus.button_index = 4'd2;
    bus.button_pressed = 1'b1;
    cyc(2);
    bus.button_pressed = 1'b0;
    cyc(1);
    checks++; if (bus.pattern !== 16'h0005) begin errors++; $display("FAIL pattern_setup got %h want 0005", bus.pattern); end
    bus.run = 1'b1;
    cyc(1);
    checks++; if (bus.running !== 1'b1 || bus.step_tick !== 1'b1 || bus.playhead !== 4'd0 || bus.step_trigger !== 1'b1) begin
      errors++; $display("FAIL play_start got run=%b tick=%b ph=%0d trig=%b want 1 1 0 1", bus.running, bus.step_tick, bus.playhead, bus.step_trigger);
    end
    for (int s = 1; s <= 16; s++) begin
      for (int k = 0; k < 3; k++) begin
        cyc(1);
        checks++; if (bus.step_tick !== 1'b0 || bus.step_trigger !== 1'b0) begin errors++; $display("FAIL play_gap step %0d got %b%b want 00", s, bus.step_tick, bus.step_trigger); end
      end
      cyc(1);
      exp_trig = ((s % 16) == 0) || ((s % 16) == 2);
      checks++; if (bus.step_tick !== 1'b1 || bus.playhead !== 4'(s % 16) || bus.step_trigger !== exp_trig) begin
        errors++; $display("FAIL play_step %0d got tick=%b ph=%0d trig=%b want 1 %0d %b", s, bus.step_tick, bus.playhead, bus.step_trigger, s % 16, exp_trig);
      end
    end
  endtask

  task automatic test_collision();
    // Just saw the tick for step 0; arrange the toggle of bit 1 to land on
    // the same edge as the step-1 tick.
    cyc(2);
    bus.button_index = 4'd1;
    bus.button_pressed = 1'b1;
    cyc(2);
    checks++; if (bus.step_tick !== 1'b1 || bus.playhead !== 4'd1 || bus.step_trigger !== 1'b0) begin
      errors++; $display("FAIL collide_trig_old got tick=%b ph=%0d trig=%b want 1 1 0", bus.step_tick, bus.playhead, bus.step_trigger);
    end
    checks++; if (bus.pattern !== 16'h0007) begin errors++; $display("FAIL collide_toggle got %h want 0007", bus.pattern); end
    bus.button_pressed = 1'b0;
    cyc(1);
    bus.button_index = 4'd3;
    bus.button_pressed = 1'b1;
    cyc(1);
    bus.clear = 1'b1;
    cyc(1);
    bus.clear = 1'b0;
    checks++; if (bus.pattern !== 16'h0000) begin errors++; $display("FAIL clear_priority got %h want 0000", bus.pattern); end
    bus.button_pressed = 1'b0;
    cyc(1);
    bus.button_pressed = 1'b1;
    cyc(2);
    checks++; if (bus.pattern !== 16'h0000) begin errors++; $display("FAIL clear_hold got %h want 0000", bus.pattern); end
    bus.button_pressed = 1'b0;
  endtask

  task automatic test_stop_restart();
    bit found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc(1);
      if (bus.step_tick === 1'b1 && bus.playhead === 4'd7) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL wait_ph7 got timeout want tick at playhead 7"); end
    bus.run = 1'b0;
    cyc(1);
    checks++; if (bus.running !== 1'b0 || bus.playhead !== 4'd7 || bus.step_tick !== 1'b0) begin
      errors++; $display("FAIL stop got run=%b ph=%0d tick=%b want 0 7 0", bus.running, bus.playhead, bus.step_tick);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      checks++; if (bus.playhead !== 4'd7 || bus.step_tick !== 1'b0 || bus.step_trigger !== 1'b0) begin
        errors++; $display("FAIL stop_hold got ph=%0d tick=%b trig=%b want 7 0 0", bus.playhead, bus.step_tick, bus.step_trigger);
      end
    end
    bus.run = 1'b1;
    cyc(1);
    checks++; if (bus.running !== 1'b1 || bus.step_tick !== 1'b1 || bus.playhead !== 4'd0) begin
      errors++; $display("FAIL restart got run=%b tick=%b ph=%0d want 1 1 0", bus.running, bus.step_tick, bus.playhead);
    end
  endtask

  task automatic test_reset_midplay();
    bus.button_index = 4'd9;
    bus.button_pressed = 1'b1;
    cyc(2);
    bus.button_pressed = 1'b0;
    checks++; if (bus.pattern !== 16'h0200) begin errors++; $display("FAIL midplay_pattern got %h want 0200", bus.pattern); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.pattern !== 16'h0000 || bus.running !== 1'b0 || bus.playhead !== 4'd0 || bus.step_tick !== 1'b0) begin
      errors++; $display("FAIL async_reset got pat=%h run=%b ph=%0d tick=%b want 0000 0 0 0", bus.pattern, bus.running, bus.playhead, bus.step_tick);
    end
    bus.run = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(2);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_held_key();
    test_playback();
    test_collision();
    test_stop_restart();
    test_reset_midplay();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
